// File: rtl/add_seq_wide.sv
// add_seq_wide: WORDS x 32-bit addition, one word per cycle through a single Kogge-Stone adder.
// Optional feature macro ADD_SEQ_SUB_EN adds the sub port (A-B via inverted B words, carry-in forced to 1).

module kogge_stone_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  // Parallel-prefix generate/propagate tree; carry-in folded in after the prefix stage.
  function automatic logic [32:0] ks_add(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [31:0] g, p, gn, pn, p0;
    logic [32:0] c;
    g  = a & b;
    p  = a ^ b;
    p0 = p;
    for (int l = 0; l < 5; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < 32; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    c[0] = ci;
    for (int i = 0; i < 32; i++) begin
      c[i + 1] = g[i] | (p[i] & ci);
    end
    return {c[32], p0 ^ c[31:0]};
  endfunction

  assign {cout_o, sum_o} = ks_add(a_i, b_i, cin_i);

endmodule

module add_seq_wide #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [32*WORDS-1:0] op_a,
  input  logic [32*WORDS-1:0] op_b,
  input  logic                cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [32*WORDS-1:0] result,
  output logic                cout,
  output logic                ovf
);

  localparam int W     = 32 * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cin_q, cin_d, carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
`ifdef ADD_SEQ_SUB_EN
  logic             sub_q, sub_d;
`endif
  logic [31:0]      a_word_s, b_word_s, sum_s;
  logic             add_cin_s, add_cout_s, accept_s, msb_cin_s;

  // Word slice feeding the shared adder; word 0 takes the captured carry-in, later words the chained carry.
  always_comb begin
    a_word_s = a_q[{idx_q, 5'd0} +: 32];
`ifdef ADD_SEQ_SUB_EN
    if (sub_q) begin
      b_word_s = ~b_q[{idx_q, 5'd0} +: 32];
    end else begin
      b_word_s = b_q[{idx_q, 5'd0} +: 32];
    end
    if (idx_q == IDX_W'(0)) begin
      add_cin_s = sub_q ? 1'b1 : cin_q;
    end else begin
      add_cin_s = carry_q;
    end
`else
    b_word_s = b_q[{idx_q, 5'd0} +: 32];
    if (idx_q == IDX_W'(0)) begin
      add_cin_s = cin_q;
    end else begin
      add_cin_s = carry_q;
    end
`endif
  end

  kogge_stone_32 u_adder (
    .a_i    (a_word_s),
    .b_i    (b_word_s),
    .cin_i  (add_cin_s),
    .sum_o  (sum_s),
    .cout_o (add_cout_s)
  );

  assign accept_s  = start & ((state_q == IDLE) | (state_q == FIN));
  // Carry into the top bit is recovered from the top word's operand and sum bits.
  assign msb_cin_s = a_word_s[31] ^ b_word_s[31] ^ sum_s[31];

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
`ifdef ADD_SEQ_SUB_EN
    sub_d    = sub_q;
`endif
    idx_d    = idx_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, FIN: begin
        if (accept_s) begin
          a_d     = op_a;
          b_d     = op_b;
          cin_d   = cin;
`ifdef ADD_SEQ_SUB_EN
          sub_d   = sub;
`endif
          idx_d   = IDX_W'(0);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[{idx_q, 5'd0} +: 32] = sum_s;
        carry_d = add_cout_s;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          state_d  = FIN;
          result_d = acc_d;
          cout_d   = add_cout_s;
          ovf_d    = msb_cin_s ^ add_cout_s;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_q    <= 1'b0;
`endif
      idx_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
`ifdef ADD_SEQ_SUB_EN
      sub_q    <= sub_d;
`endif
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_add_seq_wide.sv
// Directed bench for add_seq_wide (WORDS=4); sub vectors are exercised when ADD_SEQ_SUB_EN is defined.

module tb_add_seq_wide;

  localparam int W = 128;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef ADD_SEQ_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int           vectors;
  int           miscompares;
  logic [W-1:0] prev_res;

  add_seq_wide #(.WORDS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
`ifdef ADD_SEQ_SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation: accept edge, four RUN cycles with scrambled inputs, then FIN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W-1:0] er, input logic ec, input logic eo,
                       input bit chain, input string tag);
    op_a  = a;
    op_b  = b;
    cin   = ci;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk({tag, "_busy"}, W'(busy), W'(1'b1));
      chk({tag, "_nodone"}, W'(done), W'(1'b0));
      chk({tag, "_hold"}, result, prev_res);
      op_a  = {$urandom, $urandom, $urandom, $urandom};
      op_b  = {$urandom, $urandom, $urandom, $urandom};
      cin   = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
      sub   = 1'($urandom);
`endif
      start = (k < 4) ? 1'($urandom) : 1'b1;
      tick();
    end
    chk({tag, "_done"}, W'(done), W'(1'b1));
    chk({tag, "_fin_busy"}, W'(busy), W'(1'b0));
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, W'(cout), W'(ec));
    chk({tag, "_ovf"}, W'(ovf), W'(eo));
    prev_res = er;
    if (!chain) begin
      start = 1'b0;
      tick();
      chk({tag, "_idle_done"}, W'(done), W'(1'b0));
      chk({tag, "_idle_busy"}, W'(busy), W'(1'b0));
      chk({tag, "_idle_hold"}, result, er);
    end
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] maxpos;
    logic [W-1:0] minneg;
    logic [W-1:0] mix_a;
    logic [W-1:0] mix_b;
    logic [W-1:0] mix_r;
    vectors     = 0;
    miscompares = 0;
    prev_res    = '0;
    ones        = {W{1'b1}};
    maxpos      = {1'b0, {(W-1){1'b1}}};
    minneg      = {1'b1, {(W-1){1'b0}}};
    mix_a       = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    mix_b       = 128'h11111111_11111111_F0123457_789ABCDF;
    mix_r       = 128'h23456789_ABCDF002_00000001_00000000;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    sub   = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_done", W'(done), W'(1'b0));
    chk("rst_result", result, '0);
    chk("rst_cout", W'(cout), W'(1'b0));
    chk("rst_ovf", W'(ovf), W'(1'b0));
    rst_n = 1'b1;

    // First start lands on the first edge after release.
    do_op(128'h00000001_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0,
          128'h00000002_00000000_00000000_00000000, 1'b0, 1'b0, 1'b0, "carry_chain");
    do_op(ones, 128'd0, 1'b1, 128'd0, 1'b1, 1'b0, 1'b0, "ones_cin");
    do_op(maxpos, 128'd1, 1'b0, minneg, 1'b0, 1'b1, 1'b0, "pos_ovf");
    do_op(minneg, minneg, 1'b0, 128'd0, 1'b1, 1'b1, 1'b0, "neg_ovf");
    do_op(mix_a, mix_b, 1'b0, mix_r, 1'b0, 1'b0, 1'b0, "mixed");

    // Back-to-back with start held high throughout.
    do_op(ones, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0, 1'b1, "b2b_0");
    do_op(mix_a, mix_b, 1'b0, mix_r, 1'b0, 1'b0, 1'b1, "b2b_1");
    do_op(maxpos, 128'd1, 1'b0, minneg, 1'b0, 1'b1, 1'b0, "b2b_2");

    // Reset in the middle of RUN (word index 2).
    op_a  = mix_a;
    op_b  = mix_b;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", W'(busy), W'(1'b0));
    chk("midrst_done", W'(done), W'(1'b0));
    chk("midrst_result", result, '0);
    chk("midrst_cout", W'(cout), W'(1'b0));
    chk("midrst_ovf", W'(ovf), W'(1'b0));
    #1 rst_n = 1'b1;
    prev_res = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("postrst_nodone", W'(done), W'(1'b0));
      chk("postrst_idle", W'(busy), W'(1'b0));
    end
    do_op(mix_a, mix_b, 1'b0, mix_r, 1'b0, 1'b0, 1'b0, "after_rst");

`ifdef ADD_SEQ_SUB_EN
    sub = 1'b1;
    do_op(128'd5, 128'd7, 1'b0, {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0, 1'b0, "sub_neg");
    sub = 1'b1;
    do_op(128'd7, 128'd5, 1'b0, 128'd2, 1'b1, 1'b0, 1'b0, "sub_pos");
    sub = 1'b1;
    do_op(minneg, 128'd1, 1'b0, maxpos, 1'b1, 1'b1, 1'b0, "sub_ovf");
    sub = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_seq_wide.md
ADD_SEQ_WIDE -- requirements
Module: add_seq_wide

Interface
REQ-001 Parameter WORDS, default 4: number of 32-bit words per operand; legal range 2..8; operand width W = 32*WORDS.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled on rising edge of clk.
REQ-005 op_a  input  W  augend; captured when start is accepted.
REQ-006 op_b  input  W  addend; captured when start is accepted.
REQ-007 cin  input  1  carry into word 0; captured when start is accepted.
REQ-008 sub  input  1  subtract select; present only with ADD_SEQ_SUB_EN; captured when start is accepted.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking result/cout/ovf valid.
REQ-011 result  output  W  registered W-bit sum.
REQ-012 cout  output  1  registered carry out of bit W-1.
REQ-013 ovf  output  1  registered two's-complement signed overflow of the W-bit result.

Function
REQ-014 Block instantiates exactly one kogge_stone_32 and computes the W-bit sum as WORDS sequential 32-bit additions, least significant word first.
REQ-015 FSM states: IDLE, RUN, FIN; reset state IDLE.
REQ-016 start accepted only in IDLE or FIN; accept captures op_a, op_b, cin (and sub) into internal registers, clears word index to 0, enters RUN.
REQ-017 start in RUN ignored; captured operands and progress unaffected.
REQ-018 RUN, each cycle: adder gets word[idx] of captured A and B, carry-in = cin for idx 0, else the registered cout of the previous word; the 32-bit sum is stored into word[idx] of an internal accumulator and the adder cout into the carry register.
REQ-019 RUN with idx < WORDS-1: idx increments, stays in RUN; idx = WORDS-1: transitions to FIN.
REQ-020 RUN to FIN transition loads result from the accumulator, cout from final-word carry, ovf = carry into bit W-1 XOR carry out of bit W-1.
REQ-021 Latency: start sampled high at edge T gives busy high in cycles T+1..T+WORDS, done high only in cycle T+WORDS+1, busy low in that cycle.
REQ-022 FIN lasts one cycle; next state RUN if start high, else IDLE; back-to-back starts give one done every WORDS+1 cycles.
REQ-023 result, cout, ovf hold their values from FIN until the next completed operation; they do not change during RUN.
REQ-024 Operands changing after acceptance have no effect on the operation in flight.
REQ-025 Arithmetic modulo 2^W; all-ones + 1 wraps to 0 with cout=1.

Reset
REQ-026 rst_n low asynchronously forces IDLE, idx=0, carry register 0, busy=0, done=0, result=0, cout=0, ovf=0.
REQ-027 Reset asserted mid-RUN aborts the operation; no done pulse is produced for it after release.
REQ-028 First start is accepted on the first rising edge with rst_n high.

Configuration
REQ-029 Macro ADD_SEQ_SUB_EN defined: sub port exists; sub=1 at accept makes every B word bitwise-inverted into the adder and carry-in to word 0 = 1 (cin ignored), giving A-B; cout=1 means no borrow; ovf is the signed subtract overflow.
REQ-030 ADD_SEQ_SUB_EN undefined: sub port absent, addition only, no inversion logic present.

Verification
REQ-031 WORDS=4, A=0x0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> done at T+5, result=0x0000_0002_0000_0000_0000_0000_0000_0000, cout=0, ovf=0.
REQ-032 A=all-ones, B=0, cin=1 -> result=0, cout=1, ovf=0; A=0x7FFF...F, B=1, cin=0 -> result=0x8000...0, ovf=1, cout=0.
REQ-033 start held high continuously for 3 operations -> done at T+5, T+10, T+15; start pulses during RUN ignored, operands toggled during RUN do not alter result.
REQ-034 rst_n pulsed low during RUN idx=2 -> all outputs 0 immediately, no done afterwards; new start then completes correctly.
REQ-035 With ADD_SEQ_SUB_EN: sub=1, A=5, B=7 -> result=all-ones minus 1 (i.e. -2), cout=0; sub=1, A=7, B=5 -> result=2, cout=1.
